midi_event_decoder: RTL

Parametrised MIDI byte-stream decoder that succeeds the single-purpose note/CC74 parser. It sits between the UART byte receiver and the voice allocator / modulation router, and shares the `clk_50m` domain. It handles full running status, all channel-voice message lengths, an optional channel filter, generic CC, program change and 14-bit pitch bend. It also skips SysEx and system-common data, and passes realtime bytes through without disturbing message state.

---
 rtl/midi_event_decoder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/midi_event_decoder.sv
// MIDI byte-stream decoder: running status, channel filter, note/CC/program/pitch-bend
// events, SysEx and system-common skipping, realtime pass-through.
module midi_event_decoder #(
  parameter bit         OMNI          = 1'b1,
  parameter logic [3:0] LISTEN_CH     = 4'd0,
  parameter bit         NOTE_OFF_VEL0 = 1'b1
) (
  input  logic        clk_50m,
  input  logic        rst_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        ev_valid,
  output logic        ev_on,
  output logic [6:0]  ev_note,
  output logic [6:0]  ev_vel,
  output logic        cc_valid,
  output logic [6:0]  cc_num,
  output logic [6:0]  cc_val,
  output logic        pc_valid,
  output logic [6:0]  pc_num,
  output logic        pb_valid,
  output logic [13:0] pb_val,
  output logic [3:0]  out_chan,
  output logic        rt_valid,
  output logic [7:0]  rt_byte
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_D1, ST_D2, ST_SYSEX, ST_SKIP1, ST_SKIP2
  } state_t;

  state_t     state, state_nx;
  logic [7:0] run_stat, run_nx;
  logic [6:0] d1, d1_nx;
  logic       done;

  logic is_rt, is_sys, is_chan, one_byte, chan_ok, emit;

  assign is_rt    = (byte_data >= 8'hF8);
  assign is_sys   = (byte_data[7:3] == 5'b11110);
  assign is_chan  = byte_data[7] && (byte_data[7:4] != 4'hF);
  // Cx (program change) and Dx (channel pressure) carry a single data byte
  assign one_byte = (run_stat[7:5] == 3'b110);
  assign chan_ok  = OMNI || (run_stat[3:0] == LISTEN_CH);
  assign emit     = done && chan_ok;

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      run_stat <= 8'h00;
    end else begin
      state    <= state_nx;
      run_stat <= run_nx;
    end
  end

  // The first data byte is only meaningful after an ST_D1 capture, so it needs no reset
  always_ff @(posedge clk_50m) begin
    d1 <= d1_nx;
  end

  always_comb begin
    state_nx = state;
    run_nx   = run_stat;
    d1_nx    = d1;
    done     = 1'b0;
    if (byte_valid && !is_rt) begin
      if (is_chan) begin
        run_nx   = byte_data;
        state_nx = ST_D1;
      end else if (is_sys) begin
        run_nx = 8'h00;
        unique case (byte_data[2:0])
          3'd0:       state_nx = ST_SYSEX;
          3'd1, 3'd3: state_nx = ST_SKIP1;
          3'd2:       state_nx = ST_SKIP2;
          default:    state_nx = ST_IDLE;
        endcase
      end else begin
        unique case (state)
          ST_D1: begin
            d1_nx = byte_data[6:0];
            if (one_byte) done = 1'b1;
            else          state_nx = ST_D2;
          end
          ST_D2: begin
            done     = 1'b1;
            state_nx = ST_D1;
          end
          ST_SKIP1: state_nx = ST_IDLE;
          ST_SKIP2: state_nx = ST_SKIP1;
          default:  state_nx = state;
        endcase
      end
    end
  end

  // Output stage: pulses one cycle after the completing byte; fields hold between pulses
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      ev_valid <= 1'b0;
      ev_on    <= 1'b0;
      ev_note  <= 7'd0;
      ev_vel   <= 7'd0;
      cc_valid <= 1'b0;
      cc_num   <= 7'd0;
      cc_val   <= 7'd0;
      pc_valid <= 1'b0;
      pc_num   <= 7'd0;
      pb_valid <= 1'b0;
      pb_val   <= 14'd0;
      out_chan <= 4'd0;
      rt_valid <= 1'b0;
      rt_byte  <= 8'd0;
    end else begin
      ev_valid <= 1'b0;
      cc_valid <= 1'b0;
      pc_valid <= 1'b0;
      pb_valid <= 1'b0;
      rt_valid <= 1'b0;
      if (byte_valid && is_rt) begin
        rt_valid <= 1'b1;
        rt_byte  <= byte_data;
      end
      if (emit) begin
        unique case (run_stat[7:4])
          4'h8: begin
            ev_valid <= 1'b1;
            ev_on    <= 1'b0;
            ev_note  <= d1;
            ev_vel   <= byte_data[6:0];
            out_chan <= run_stat[3:0];
          end
          4'h9: begin
            ev_valid <= 1'b1;
            ev_on    <= (byte_data[6:0] != 7'd0) || !NOTE_OFF_VEL0;
            ev_note  <= d1;
            ev_vel   <= byte_data[6:0];
            out_chan <= run_stat[3:0];
          end
          4'hB: begin
            cc_valid <= 1'b1;
            cc_num   <= d1;
            cc_val   <= byte_data[6:0];
            out_chan <= run_stat[3:0];
          end
          4'hC: begin
            pc_valid <= 1'b1;
            pc_num   <= byte_data[6:0];
            out_chan <= run_stat[3:0];
          end
          4'hE: begin
            pb_valid <= 1'b1;
            pb_val   <= {byte_data[6:0], d1};
            out_chan <= run_stat[3:0];
          end
          default: ;
        endcase
      end
    end
  end

endmodule
